// File: rtl/voxel_score_mac_pkg.sv
// Shared constants, enums and the saturating accumulate helper for the
// voxel-bin gesture scoring path.
`timescale 1ns/1ps
package voxel_pkg;

    localparam int NUM_CLASSES   = 4;
    localparam int GRID_SIZE     = 16;
    localparam int NUM_BINS      = 4;
    localparam int CELLS_PER_BIN = GRID_SIZE * GRID_SIZE;
    localparam int NUM_CELLS     = NUM_BINS * CELLS_PER_BIN;
    localparam int VOXEL_BITS    = 8;
    localparam int WEIGHT_BITS   = 8;
    localparam int ACC_BITS      = 24;
    localparam int PROD_BITS     = VOXEL_BITS + WEIGHT_BITS + 1;
    localparam int ADDR_BITS     = $clog2(NUM_CELLS);
    localparam int CLS_BITS      = $clog2(NUM_CLASSES);

    localparam logic signed [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

    typedef enum logic [CLS_BITS-1:0] {
        CLS_UP    = 2'd0,
        CLS_DOWN  = 2'd1,
        CLS_LEFT  = 2'd2,
        CLS_RIGHT = 2'd3
    } class_idx_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        DRAIN  = 3'd2,
        ARGMAX = 3'd3,
        DONE   = 3'd4
    } mac_state_t;

    // Adds a signed product term to a signed accumulator one bit wider than
    // the accumulator, then clamps to the accumulator range. Not sticky: a
    // clamped value can move back inside the range on later terms.
    function automatic logic signed [ACC_BITS-1:0] sat_add(
        input logic signed [ACC_BITS-1:0]  acc,
        input logic signed [PROD_BITS-1:0] term
    );
        logic [ACC_BITS:0] sum;
        sum = {acc[ACC_BITS-1], acc} + {{(ACC_BITS+1-PROD_BITS){term[PROD_BITS-1]}}, term};
        if (sum[ACC_BITS] != sum[ACC_BITS-1]) begin
            sat_add = sum[ACC_BITS] ? ACC_MIN : ACC_MAX;
        end else begin
            sat_add = sum[ACC_BITS-1:0];
        end
    endfunction

endpackage

// File: rtl/voxel_score_mac_if.sv
// Bus between the scoring MAC, the voxel memory / weight ROMs and the
// gesture output logic.
//
// Handshake: start is a one-cycle request honoured only while busy is low;
// busy stays high from the cycle after an accepted start until the scan
// completes. cell_addr is the shared read address; voxel_data and
// weight_data must carry the contents of that address exactly one cycle
// later. result_valid is a one-cycle pulse with no back-pressure: the
// consumer must take result_class/result_score in that cycle, while scores
// stays stable until the next accepted start.
`timescale 1ns/1ps
interface voxel_score_mac_if;
    import voxel_pkg::*;

    logic                                start;
    logic                                busy;
    logic [ADDR_BITS-1:0]                cell_addr;
    logic [VOXEL_BITS-1:0]               voxel_data;
    logic [NUM_CLASSES*WEIGHT_BITS-1:0]  weight_data;
    logic                                result_valid;
    logic [CLS_BITS-1:0]                 result_class;
    logic [ACC_BITS-1:0]                 result_score;
    logic [NUM_CLASSES*ACC_BITS-1:0]     scores;
    mac_state_t                          fsm_state;

    modport slave (
        input  start, voxel_data, weight_data,
        output busy, cell_addr, result_valid, result_class, result_score,
               scores, fsm_state
    );

    modport master (
        output start, voxel_data, weight_data,
        input  busy, cell_addr, result_valid, result_class, result_score,
               scores, fsm_state
    );

endinterface

// File: rtl/voxel_score_mac_score_lane.sv
// One class lane: unsigned voxel times signed weight, accumulated with
// saturation. Cleared at the start of every scan.
`timescale 1ns/1ps
module score_lane
    import voxel_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          en,
    input  logic [VOXEL_BITS-1:0]         voxel,
    input  logic signed [WEIGHT_BITS-1:0] weight,
    output logic signed [ACC_BITS-1:0]    acc
);

    logic signed [PROD_BITS-1:0] voxel_ext;
    logic signed [PROD_BITS-1:0] weight_ext;
    logic signed [PROD_BITS-1:0] prod;

    // The true product always fits PROD_BITS, so a PROD_BITS-wide multiply
    // of the extended operands is exact.
    assign voxel_ext  = {{(PROD_BITS-VOXEL_BITS){1'b0}}, voxel};
    assign weight_ext = {{(PROD_BITS-WEIGHT_BITS){weight[WEIGHT_BITS-1]}}, weight};
    assign prod       = voxel_ext * weight_ext;

    // Saturating accumulator with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= sat_add(acc, prod);
        end
    end

endmodule

// File: rtl/voxel_score_mac.sv
// Scans every voxel cell once, accumulates per-class voxel.weight dot
// products in parallel lanes, then picks the best class sequentially.
`timescale 1ns/1ps
module voxel_score_mac
    import voxel_pkg::*;
(
    input logic             clk,
    input logic             rst,
    voxel_score_mac_if.slave bus
);

    mac_state_t                      state;
    logic                            busy_q;
    logic [ADDR_BITS-1:0]            addr_q;
    logic                            data_valid;
    logic [CLS_BITS-1:0]             arg_idx;
    class_idx_t                      best_idx;
    logic signed [ACC_BITS-1:0]      best_score;
    logic                            result_valid_q;
    logic [CLS_BITS-1:0]             result_class_q;
    logic [ACC_BITS-1:0]             result_score_q;
    logic [NUM_CLASSES*ACC_BITS-1:0] scores_q;

    logic                            lane_clear;
    logic signed [ACC_BITS-1:0]      lane_acc [NUM_CLASSES];
    logic [NUM_CLASSES*ACC_BITS-1:0] scores_flat;

    logic signed [ACC_BITS-1:0]      cand;
    logic                            take;
    class_idx_t                      next_best_idx;
    logic signed [ACC_BITS-1:0]      next_best_score;

    assign lane_clear = (state == IDLE) && bus.start;

    // data_valid marks cycles where voxel/weight data belong to an address
    // issued during SCAN; it drives all lanes at once.
    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_lane
        score_lane u_lane (
            .clk    (clk),
            .rst    (rst),
            .clear  (lane_clear),
            .en     (data_valid),
            .voxel  (bus.voxel_data),
            .weight (bus.weight_data[k*WEIGHT_BITS +: WEIGHT_BITS]),
            .acc    (lane_acc[k])
        );
    end

    // Pack lane accumulators for the scores snapshot.
    always_comb begin
        scores_flat = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            scores_flat[k*ACC_BITS +: ACC_BITS] = lane_acc[k];
        end
    end

    // One argmax step: class 0 seeds best, later classes win only when
    // strictly greater so ties stay with the lowest index.
    always_comb begin
        cand            = lane_acc[arg_idx];
        take            = (arg_idx == '0) || (cand > best_score);
        next_best_idx   = take ? class_idx_t'(arg_idx) : best_idx;
        next_best_score = take ? cand : best_score;
    end

    // Main sequencer: address counter, drain, argmax walk and result capture.
    // Results are captured on the transition into DONE so they are already
    // valid while result_valid is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            busy_q         <= 1'b0;
            addr_q         <= '0;
            data_valid     <= 1'b0;
            arg_idx        <= '0;
            best_idx       <= CLS_UP;
            best_score     <= '0;
            result_valid_q <= 1'b0;
            result_class_q <= '0;
            result_score_q <= '0;
            scores_q       <= '0;
        end else begin
            result_valid_q <= 1'b0;
            data_valid     <= (state == SCAN);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        addr_q <= '0;
                        busy_q <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (addr_q == ADDR_BITS'(NUM_CELLS - 1)) begin
                        state <= DRAIN;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    arg_idx <= '0;
                    state   <= ARGMAX;
                end
                ARGMAX: begin
                    best_idx   <= next_best_idx;
                    best_score <= next_best_score;
                    if (arg_idx == CLS_BITS'(NUM_CLASSES - 1)) begin
                        result_valid_q <= 1'b1;
                        result_class_q <= next_best_idx;
                        result_score_q <= next_best_score;
                        scores_q       <= scores_flat;
                        state          <= DONE;
                    end else begin
                        arg_idx <= arg_idx + 1'b1;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.cell_addr    = addr_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_class = result_class_q;
    assign bus.result_score = result_score_q;
    assign bus.scores       = scores_q;
    assign bus.fsm_state    = state;

endmodule

// File: tb/tb_voxel_score_mac.sv
// Directed bench for voxel_score_mac with a 1-cycle-latency memory/ROM model.
`timescale 1ns/1ps
module tb_voxel_score_mac;
    import voxel_pkg::*;

    logic clk;
    logic rst;
    int   vox_mode;
    int   wt_mode;
    int   n_assert;
    int   n_fail;

    voxel_score_mac_if bus ();

    voxel_score_mac dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // voxel value for an address; spatial = cy*16 + cx within each bin
    function automatic logic [VOXEL_BITS-1:0] vox_fn(input logic [ADDR_BITS-1:0] a);
        int cy;
        cy = int'(a[7:4]);
        case (vox_mode)
            0:       return 8'd1;
            1:       return (cy >= 8) ? 8'd10 : 8'd0;
            2:       return 8'd255;
            default: return 8'd0;
        endcase
    endfunction

    // weights: mode 0 models the trained ROMs (UP/DOWN split on cy, LEFT/RIGHT on cx)
    function automatic logic [NUM_CLASSES*WEIGHT_BITS-1:0] wt_fn(input logic [ADDR_BITS-1:0] a);
        logic [NUM_CLASSES*WEIGHT_BITS-1:0] res;
        int cy, cx, w;
        cy = int'(a[7:4]);
        cx = int'(a[3:0]);
        res = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (wt_mode == 1) w = 127;
            else if (wt_mode == 2) w = -128;
            else begin
                case (k)
                    0:       w = (cy >= 8) ? -36 : 54;
                    1:       w = (cy >= 8) ? 54 : -36;
                    2:       w = (cx < 8) ? 27 : -9;
                    default: w = (cx < 8) ? -9 : 27;
                endcase
            end
            res[k*WEIGHT_BITS +: WEIGHT_BITS] = w[7:0];
        end
        return res;
    endfunction

    // memory / ROM responder: registered read of the shared address
    always @(posedge clk) begin
        bus.voxel_data  <= vox_fn(bus.cell_addr);
        bus.weight_data <= wt_fn(bus.cell_addr);
    end

    function automatic longint score_of(input int k);
        logic signed [ACC_BITS-1:0] s;
        s = bus.scores[k*ACC_BITS +: ACC_BITS];
        return longint'(s);
    endfunction

    function automatic longint res_score();
        logic signed [ACC_BITS-1:0] s;
        s = bus.result_score;
        return longint'(s);
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"},  longint'(bus.busy), 0);
        check({tag, "_addr"},  longint'(bus.cell_addr), 0);
        check({tag, "_rv"},    longint'(bus.result_valid), 0);
        check({tag, "_class"}, longint'(bus.result_class), 0);
        check({tag, "_score"}, res_score(), 0);
        check({tag, "_scores"}, longint'(bus.scores == '0), 1);
        check({tag, "_state"}, longint'(bus.fsm_state), longint'(IDLE));
    endtask

    task automatic check_scores(input string tag, input longint e0, input longint e1,
                                input longint e2, input longint e3);
        check({tag, "_up"},    score_of(0), e0);
        check({tag, "_down"},  score_of(1), e1);
        check({tag, "_left"},  score_of(2), e2);
        check({tag, "_right"}, score_of(3), e3);
    endtask

    // Issue start, then run a fixed 1100-cycle window. With poke set, start is
    // pulsed during SCAN and again so that it is sampled in the DONE cycle.
    task automatic do_run(input bit poke, output int vcount, output int vcyc,
                          output int bad_steps, output int max_addr, output int first_addr);
        int prev, a;
        vcount = 0; vcyc = -1; bad_steps = 0; max_addr = 0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        first_addr = int'(bus.cell_addr);
        prev = first_addr;
        for (int n = 1; n <= 1100; n++) begin
            if (poke && (n % 100 == 50) && (n < 1000)) bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            a = int'(bus.cell_addr);
            if (bus.busy) begin
                if (a != prev && a != prev + 1) bad_steps++;
                if (a > max_addr) max_addr = a;
                prev = a;
            end
            if (bus.result_valid) begin
                vcount++;
                if (vcyc < 0) begin
                    vcyc = n + 1;
                    if (poke) bus.start = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int vc, vcyc, bad, maxa, firsta, seen, hit;
        n_assert = 0; n_fail = 0;
        rst = 1'b1; bus.start = 1'b0; vox_mode = 0; wt_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // uniform voxels, model ROMs: all four classes tie
        vox_mode = 0; wt_mode = 0;
        do_run(1'b0, vc, vcyc, bad, maxa, firsta);
        check_scores("uni", 9216, 9216, 9216, 9216);
        check("uni_class", longint'(bus.result_class), longint'(CLS_UP));
        check("uni_score", res_score(), 9216);
        check("uni_rv_count", vc, 1);
        check("uni_rv_cycle", vcyc, 1030);
        check("uni_busy_end", longint'(bus.busy), 0);

        // lower half of the grid active
        vox_mode = 1;
        do_run(1'b0, vc, vcyc, bad, maxa, firsta);
        check_scores("half", -184320, 276480, 46080, 46080);
        check("half_class", longint'(bus.result_class), longint'(CLS_DOWN));
        check("half_score", res_score(), 276480);
        check("half_rv_count", vc, 1);

        // positive saturation
        vox_mode = 2; wt_mode = 1;
        do_run(1'b0, vc, vcyc, bad, maxa, firsta);
        check_scores("satp", 8388607, 8388607, 8388607, 8388607);
        check("satp_class", longint'(bus.result_class), 0);
        check("satp_score", res_score(), 8388607);

        // negative saturation
        wt_mode = 2;
        do_run(1'b0, vc, vcyc, bad, maxa, firsta);
        check_scores("satn", -8388608, -8388608, -8388608, -8388608);
        check("satn_class", longint'(bus.result_class), 0);
        check("satn_score", res_score(), -8388608);

        // reset in the middle of a scan
        vox_mode = 1; wt_mode = 0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        hit = 0;
        for (int n = 0; n < 600 && hit == 0; n++) begin
            if (int'(bus.cell_addr) == 500) hit = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("midrst_reach_500", hit, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_cleared("midrst");
        seen = 0;
        for (int n = 0; n < 1100; n++) begin
            @(posedge clk); #1;
            if (bus.result_valid) seen++;
        end
        check("midrst_no_rv", seen, 0);
        check("midrst_idle", longint'(bus.busy), 0);
        do_run(1'b0, vc, vcyc, bad, maxa, firsta);
        check_scores("after_rst", -184320, 276480, 46080, 46080);
        check("after_rst_class", longint'(bus.result_class), 1);
        check("after_rst_rv_count", vc, 1);

        // start pulses during SCAN and in the DONE cycle are ignored
        vox_mode = 0;
        do_run(1'b1, vc, vcyc, bad, maxa, firsta);
        check("poke_first_addr", firsta, 0);
        check("poke_addr_steps", bad, 0);
        check("poke_max_addr", maxa, 1023);
        check("poke_rv_count", vc, 1);
        check("poke_rv_cycle", vcyc, 1030);
        check("poke_idle_end", longint'(bus.busy), 0);
        check_scores("poke", 9216, 9216, 9216, 9216);

        // back-to-back runs, second with empty voxels
        vox_mode = 1;
        do_run(1'b0, vc, vcyc, bad, maxa, firsta);
        check("b2b_first_class", longint'(bus.result_class), 1);
        vox_mode = 3;
        do_run(1'b0, vc, vcyc, bad, maxa, firsta);
        check_scores("b2b_zero", 0, 0, 0, 0);
        check("b2b_class", longint'(bus.result_class), 0);
        check("b2b_score", res_score(), 0);
        check("b2b_rv_count", vc, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/voxel_score_mac.md
Name: voxel_score_mac

Overview:
- Downstream consumer of the per-class weight ROMs in the voxel-bin gesture path.
- On `start`, it scans every voxel cell once, driving one shared cell address to the voxel memory and to all NUM_CLASSES weight ROMs.
- Per class, it accumulates the signed dot product voxel·weight, then runs a sequential argmax.
- It reports the winning class and all per-class scores to the gesture output logic.

Parameters:
- NUM_CLASSES, 4, number of gesture classes / weight ROMs (UP, DOWN, LEFT, RIGHT).
- GRID_SIZE, 16, spatial grid edge length.
- NUM_BINS, 4, number of time bins.
- NUM_CELLS, 1024, equals NUM_BINS*GRID_SIZE*GRID_SIZE; address = bin*256 + spatial.
- VOXEL_BITS, 8, unsigned voxel count width.
- WEIGHT_BITS, 8, signed weight width.
- ACC_BITS, 24, signed accumulator/score width (saturating).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a scan when IDLE.
- busy  out  1  high in every state except IDLE.
- cell_addr  out  $clog2(NUM_CELLS)  shared read address to voxel memory and all weight ROMs.
- voxel_data  in  VOXEL_BITS  voxel count; valid 1 cycle after cell_addr.
- weight_data  in  NUM_CLASSES*WEIGHT_BITS  packed signed ROM outputs, class k at bits [k*WEIGHT_BITS +: WEIGHT_BITS]; valid 1 cycle after cell_addr.
- result_valid  out  1  one-cycle pulse when results are final.
- result_class  out  $clog2(NUM_CLASSES)  argmax class index.
- result_score  out  ACC_BITS  signed score of the winning class.
- scores  out  NUM_CLASSES*ACC_BITS  packed signed per-class scores; held until the next start.

Behaviour:
- Reset values:
  - state=IDLE; busy=0; cell_addr=0; result_valid=0; result_class=0; result_score=0; scores=0.
  - Accumulators, best-index and best-score registers are cleared.
- FSM states: IDLE, SCAN, DRAIN, ARGMAX, DONE. Let cycle 0 be the edge where `start`=1 is sampled in IDLE.
  - IDLE:
    - On `start`: cell_addr←0, all accumulators←0, go to SCAN.
    - `start` is ignored in every other state.
  - SCAN, cycles 1..NUM_CELLS:
    - cell_addr = c-1 in cycle c.
    - After NUM_CELLS-1 is presented, go to DRAIN.
  - Accumulation runs in cycles 2..NUM_CELLS+1, on data for the address presented the previous cycle.
    - acc[k] ← sat(acc[k] + zext(voxel_data)·weight_data[k]).
    - Product width is VOXEL_BITS+WEIGHT_BITS+1 signed.
    - The sum is computed at ACC_BITS+1 and clamped to [-2^(ACC_BITS-1), 2^(ACC_BITS-1)-1].
    - Once saturated, an accumulator may come back off the rail on later terms; there is no sticky flag.
  - DRAIN, cycle NUM_CELLS+1: last accumulate only; no new address is issued; cell_addr holds its last value.
  - ARGMAX, cycles NUM_CELLS+2 .. NUM_CELLS+1+NUM_CLASSES:
    - Examines class k in cycle NUM_CELLS+2+k.
    - Class 0 initialises best. Later classes replace best only if strictly greater, so ties go to the lowest index.
  - DONE, cycle NUM_CELLS+2+NUM_CLASSES (1030 at defaults):
    - result_valid=1 for exactly this cycle.
    - result_class, result_score and scores are updated, then go to IDLE.
- Result outputs change only in DONE and otherwise hold their values.
- `rst` mid-operation: next state is IDLE, all outputs go to their reset values, and no result_valid is produced.
- `start` sampled in the same cycle as DONE is ignored, because the FSM is not yet in IDLE.

Decomposition:
- Shared package `voxel_pkg`:
  - GRID_SIZE, NUM_BINS, NUM_CELLS and CELLS_PER_BIN constants.
  - Class index enum (CLS_UP=0, CLS_DOWN=1, CLS_LEFT=2, CLS_RIGHT=3).
  - `mac_state_t` FSM enum.
  - Saturating-add function.
- One natural sub-module: `score_lane`, holding one class's multiplier, saturating accumulator and clear/enable.
  - The top level instantiates NUM_CLASSES lanes and owns the FSM, address counter and argmax.

Test Plan:
- Uniform voxels=1 with real weight ROMs (CLASS_IDX 0..3):
  - scores all equal 9216.
  - result_class=0 (tie rule); result_valid exactly in cycle 1030 after start.
- Voxels=10 only where cy≥8 (all bins):
  - DOWN=276480, UP=-184320, LEFT=RIGHT=46080.
  - result_class=1, result_score=276480.
- Bench-driven weight_data all 127, voxels all 255:
  - scores all saturate to 8388607.
  - Same weights at -128: scores saturate to -8388608.
- Assert rst at cell_addr=500:
  - busy=0 and all outputs zero the next cycle; no result_valid.
  - A fresh start then completes normally with the correct scores.
- Pulse start repeatedly during SCAN and in the DONE cycle:
  - Scan is not restarted; cell_addr sequence stays 0..1023 monotonic.
  - Exactly one result_valid.
- Back-to-back runs, second with all voxels=0:
  - scores all 0, result_class=0; no residue from the first run.
